// File: rtl/mips_isa_pkg.sv
// -----------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS ISA constants: primary opcodes and R-type function codes (also
// used by the control decoder), the mnemonic-level request opcode enum, and
// the encoder FSM state type.
// -----------------------------------------------------------------------------
package mips_isa_pkg;

  // Mnemonic-level request opcodes; values 10..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_J    = 4'd8,
    OP_ADDI = 4'd9
  } req_op_e;

  // Primary opcode field, instr[31:26].
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function field, instr[5:0].
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage : mips_isa_pkg

// File: rtl/mips_instr_pack.sv
// -----------------------------------------------------------------------------
// mips_instr_pack
// Purely combinational packer: mnemonic-level fields -> 32-bit MIPS word.
// Ports:
//   i_op      [3:0]   request opcode (req_op_e encoding)
//   i_rs      [4:0]   source register
//   i_rt      [4:0]   target register
//   i_rd      [4:0]   destination register (R-type only)
//   i_imm     [25:0]  imm[15:0] for I-type, imm[25:0] for J
//   o_word    [31:0]  encoded instruction (0 when illegal)
//   o_illegal         opcode outside the supported set
// -----------------------------------------------------------------------------
module mips_instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_ADD:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADD};
      OP_SUB:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUB};
      OP_AND:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_AND};
      OP_OR:   o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_OR};
      OP_SLT:  o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SLT};
      OP_LW:   o_word = {OPC_LW,   i_rs, i_rt, i_imm[15:0]};
      OP_SW:   o_word = {OPC_SW,   i_rs, i_rt, i_imm[15:0]};
      OP_BEQ:  o_word = {OPC_BEQ,  i_rs, i_rt, i_imm[15:0]};
      OP_ADDI: o_word = {OPC_ADDI, i_rs, i_rt, i_imm[15:0]};
      OP_J:    o_word = {OPC_J,    i_imm};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule : mips_instr_pack

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
// Accepts mnemonic-level instruction requests on a valid/ready stream, packs
// each into a MIPS word and writes it to instruction memory at consecutive
// word addresses starting at BASE_ADDR. Requires
// BASE_ADDR + 4*DEPTH_WORDS <= 2**ADDR_W.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   prog_start / prog_end           open a program / stop taking requests
//   req_valid, req_ready            request handshake
//   req_op, req_rs, req_rt,
//   req_rd, req_imm                 request fields
//   imem_we, imem_ready             write strobe / memory accept
//   imem_addr, imem_wdata           byte address and encoded word
//   word_count                      words written since prog_start
//   busy, done, err_illegal         status (done is a 1-cycle pulse)
// -----------------------------------------------------------------------------
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_start,
  input  logic              prog_end,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [25:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  enc_state_e        r_state;
  enc_state_e        w_state_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_count;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic [ADDR_W:0]   w_inflight;
  logic              w_full;
  logic              w_run;
  logic              w_accept;
  logic              w_complete;

  mips_instr_pack u_pack (
    .i_op      (req_op),
    .i_rs      (req_rs),
    .i_rt      (req_rt),
    .i_rd      (req_rd),
    .i_imm     (req_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // Completed writes plus the one held in the output register. Counting the
  // pending word keeps an accept-and-complete cycle from overrunning the window.
  assign w_inflight = {1'b0, r_count} + {{ADDR_W{1'b0}}, r_we};
  assign w_full     = (w_inflight >= (ADDR_W+1)'(DEPTH_WORDS));
  assign w_run      = (r_state == ST_RUN);
  assign req_ready  = w_run && !w_full && (!r_we || imem_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_complete = r_we && imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (prog_start) w_state_next = ST_RUN;
      ST_RUN:   if (prog_end)   w_state_next = ST_DRAIN;
      ST_DRAIN: if (!r_we)      w_state_next = ST_DONE;
      ST_DONE:                  w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Output register, address/count and sticky error. Later assignments win:
  // a completion clears the strobe, a same-cycle legal accept re-arms it with
  // the next word at the already-incremented address (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && prog_start) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_complete) begin
        r_we    <= 1'b0;
        r_addr  <= r_addr + ADDR_W'(4);
        r_count <= r_count + ADDR_W'(1);
      end
      if (w_accept) begin
        if (w_illegal) begin
          r_err <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
        end
      end
      // A request pushed against a full window is an overflow.
      if (w_run && req_valid && w_full) r_err <= 1'b1;
    end
  end

  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign word_count  = r_count;
  assign err_illegal = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

endmodule : mips_instr_encoder

// File: tb/tb_mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_encoder
// Directed bench for mips_instr_encoder with a 4-word program window.
// -----------------------------------------------------------------------------
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_start, prog_end, req_valid, req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rs, req_rt, req_rd;
  logic [25:0]       req_imm;
  logic              imem_we, imem_ready;
  logic [ADDR_W-1:0] imem_addr, word_count;
  logic [31:0]       imem_wdata;
  logic              busy, done, err_illegal;

  int n_checks;
  int n_pass;

  mips_instr_encoder #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (8'h00),
    .DEPTH_WORDS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_start  (prog_start),
    .prog_end    (prog_end),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .imem_we     (imem_we),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm);
    req_valid = 1'b1;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_imm   = imm;
  endtask

  task automatic open_prog();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  // Pulse prog_end and wait (bounded) for the done pulse.
  task automatic finish_prog(input string tag);
    int k;
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    tick();
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    prog_start = 1'b0;
    prog_end   = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_rs     = '0;
    req_rt     = '0;
    req_rd     = '0;
    req_imm    = '0;
    imem_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_we",    {31'd0, imem_we},     32'd0);
    check("rst_addr",  {24'd0, imem_addr},   32'h0);
    check("rst_wdata", imem_wdata,           32'h0);
    check("rst_count", {24'd0, word_count},  32'd0);
    check("rst_done",  {31'd0, done},        32'd0);
    check("rst_err",   {31'd0, err_illegal}, 32'd0);
    check("rst_ready", {31'd0, req_ready},   32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single ADD, 1-cycle latency
    imem_ready = 1'b1;
    open_prog();
    check("t1_busy", {31'd0, busy}, 32'd1);
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    #1 check("t1_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("t1_we",    {31'd0, imem_we},    32'd1);
    check("t1_addr",  {24'd0, imem_addr},  32'h00);
    check("t1_wdata", imem_wdata,          32'h00221820);
    tick();
    check("t1_we_clr", {31'd0, imem_we},   32'd0);
    check("t1_addr2",  {24'd0, imem_addr}, 32'h04);
    check("t1_count",  {24'd0, word_count}, 32'd1);
    finish_prog("t1");

    // 2: LW, SW, BEQ back to back; prog_end together with the last accept
    open_prog();
    set_req(OP_LW, 5'd29, 5'd8, 5'd0, 26'd4);
    tick();
    check("t2_lw_we",   {31'd0, imem_we},   32'd1);
    check("t2_lw_addr", {24'd0, imem_addr}, 32'h00);
    check("t2_lw",      imem_wdata,         32'h8FA80004);
    set_req(OP_SW, 5'd29, 5'd8, 5'd0, 26'd8);
    #1 check("t2_ready_busy_we", {31'd0, req_ready}, 32'd1);
    tick();
    check("t2_sw_addr", {24'd0, imem_addr},  32'h04);
    check("t2_sw",      imem_wdata,          32'hAFA80008);
    check("t2_sw_cnt",  {24'd0, word_count}, 32'd1);
    set_req(OP_BEQ, 5'd1, 5'd2, 5'd0, 26'd3);
    prog_end = 1'b1;
    tick();
    prog_end  = 1'b0;
    req_valid = 1'b0;
    check("t2_beq_addr", {24'd0, imem_addr},  32'h08);
    check("t2_beq",      imem_wdata,          32'h10220003);
    check("t2_beq_we",   {31'd0, imem_we},    32'd1);
    check("t2_drain",    {31'd0, busy},       32'd1);
    tick();
    check("t2_we_clr",  {31'd0, imem_we},    32'd0);
    check("t2_cnt",     {24'd0, word_count}, 32'd3);
    check("t2_addr_end", {24'd0, imem_addr}, 32'h0C);
    check("t2_nodone",  {31'd0, done},       32'd0);
    tick();
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    check("t2_done_low", {31'd0, done}, 32'd0);
    check("t2_idle",     {31'd0, busy}, 32'd0);

    // 3: J stalled 3 cycles, ADDI waiting (upper imm bits and rd ignored)
    open_prog();
    check("t3_addr_reset", {24'd0, imem_addr}, 32'h00);
    imem_ready = 1'b0;
    set_req(OP_J, 5'd0, 5'd0, 5'd0, 26'h100);
    tick();
    check("t3_j_we", {31'd0, imem_we}, 32'd1);
    check("t3_j",    imem_wdata,       32'h08000100);
    set_req(OP_ADDI, 5'd0, 5'd9, 5'd17, 26'h2AFFFF);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall_ready", {31'd0, req_ready}, 32'd0);
      tick();
      check("t3_stall_we",    {31'd0, imem_we},   32'd1);
      check("t3_stall_addr",  {24'd0, imem_addr}, 32'h00);
      check("t3_stall_wdata", imem_wdata,         32'h08000100);
    end
    imem_ready = 1'b1;
    #1 check("t3_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("t3_addi",      imem_wdata,          32'h2009FFFF);
    check("t3_addi_addr", {24'd0, imem_addr},  32'h04);
    check("t3_cnt1",      {24'd0, word_count}, 32'd1);
    tick();
    check("t3_cnt2",  {24'd0, word_count}, 32'd2);
    check("t3_addr8", {24'd0, imem_addr},  32'h08);
    finish_prog("t3");

    // 4: illegal op between two ADDs
    open_prog();
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    tick();
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 26'd0);
    #1 check("t4_ill_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("t4_ill_we",   {31'd0, imem_we},     32'd0);
    check("t4_err",      {31'd0, err_illegal}, 32'd1);
    check("t4_ill_addr", {24'd0, imem_addr},   32'h04);
    check("t4_ill_cnt",  {24'd0, word_count},  32'd1);
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    tick();
    req_valid = 1'b0;
    check("t4_add2_addr", {24'd0, imem_addr}, 32'h04);
    check("t4_add2",      imem_wdata,         32'h00221820);
    tick();
    check("t4_cnt",  {24'd0, word_count}, 32'd2);
    check("t4_addr", {24'd0, imem_addr},  32'h08);
    finish_prog("t4");
    check("t4_err_sticky", {31'd0, err_illegal}, 32'd1);

    // 5: window of 4 words, fifth request overflows
    open_prog();
    check("t5_err_clr", {31'd0, err_illegal}, 32'd0);
    check("t5_cnt_clr", {24'd0, word_count},  32'd0);
    set_req(OP_SUB, 5'd5, 5'd6, 5'd4, 26'd0);
    tick();
    check("t5_sub", imem_wdata, 32'h00A62022);
    set_req(OP_AND, 5'd1, 5'd1, 5'd7, 26'd0);
    tick();
    check("t5_and",      imem_wdata,         32'h00213824);
    check("t5_and_addr", {24'd0, imem_addr}, 32'h04);
    set_req(OP_OR, 5'd2, 5'd3, 5'd10, 26'd0);
    tick();
    check("t5_or",      imem_wdata,         32'h00435025);
    check("t5_or_addr", {24'd0, imem_addr}, 32'h08);
    set_req(OP_SLT, 5'd31, 5'd0, 5'd1, 26'd0);
    tick();
    check("t5_slt",      imem_wdata,          32'h03E0082A);
    check("t5_slt_addr", {24'd0, imem_addr},  32'h0C);
    check("t5_cnt3",     {24'd0, word_count}, 32'd3);
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    #1 check("t5_full_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("t5_cnt4",    {24'd0, word_count},  32'd4);
    check("t5_addr10",  {24'd0, imem_addr},   32'h10);
    check("t5_ovf_we",  {31'd0, imem_we},     32'd0);
    check("t5_ovf_err", {31'd0, err_illegal}, 32'd1);
    tick();
    check("t5_hold_we",    {31'd0, imem_we},   32'd0);
    check("t5_hold_ready", {31'd0, req_ready}, 32'd0);
    check("t5_hold_addr",  {24'd0, imem_addr}, 32'h10);
    req_valid = 1'b0;
    finish_prog("t5");

    // 6a: prog_end while a write is stalled
    open_prog();
    imem_ready = 1'b0;
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    tick();
    req_valid = 1'b0;
    prog_end  = 1'b1;
    tick();
    prog_end = 1'b0;
    check("t6_drain_busy", {31'd0, busy},    32'd1);
    check("t6_drain_we",   {31'd0, imem_we}, 32'd1);
    check("t6_drain_done", {31'd0, done},    32'd0);
    tick();
    check("t6_drain_we2",   {31'd0, imem_we}, 32'd1);
    check("t6_drain_done2", {31'd0, done},    32'd0);
    imem_ready = 1'b1;
    tick();
    check("t6_we_clr", {31'd0, imem_we},    32'd0);
    check("t6_nodone", {31'd0, done},       32'd0);
    check("t6_cnt",    {24'd0, word_count}, 32'd1);
    tick();
    check("t6_done", {31'd0, done}, 32'd1);
    tick();
    check("t6_done_low", {31'd0, done}, 32'd0);
    check("t6_idle",     {31'd0, busy}, 32'd0);

    // 6b: asynchronous reset while a write at 0x04 is stalled
    open_prog();
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    tick();
    set_req(OP_OR, 5'd2, 5'd3, 5'd10, 26'd0);
    tick();
    req_valid  = 1'b0;
    imem_ready = 1'b0;
    tick();
    check("t6_stall_addr", {24'd0, imem_addr}, 32'h04);
    check("t6_stall_we",   {31'd0, imem_we},   32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_we",    {31'd0, imem_we},    32'd0);
    check("t6_rst_addr",  {24'd0, imem_addr},  32'h00);
    check("t6_rst_wdata", imem_wdata,          32'h0);
    check("t6_rst_cnt",   {24'd0, word_count}, 32'd0);
    check("t6_rst_busy",  {31'd0, busy},       32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mips_instr_encoder
